// File: rtl/mem_loader_pkg.sv
// Shared memory-map definitions for the boot/debug loader and the memory block it feeds.
package mem_loader_pkg;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 8;
  localparam int RAM_SEL_BIT = 15;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  // The upper half of the address map is RAM; the lower half is ROM and must never be written.
  function automatic logic is_ram(input addr_t a);
    return a[RAM_SEL_BIT];
  endfunction

endpackage

// File: rtl/mem_loader_stall_timer.sv
// Counts idle stream cycles mid-packet and flags the cycle in which the count reaches TIMEOUT.
module stall_timer #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A clear in the same cycle always wins, so a late handshake can never be aborted.
  assign expired = en && !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || expired) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Byte-stream loader: parses a big-endian addr/len header, then writes len bytes to memory,
// owning the memory port while busy and passing the CPU port through when idle.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] H0    = 3'd0;
  localparam logic [2:0] H1    = 3'd1;
  localparam logic [2:0] H2    = 3'd2;
  localparam logic [2:0] H3    = 3'd3;
  localparam logic [2:0] DATA  = 3'd4;
  localparam logic [2:0] DONE0 = 3'd5;

  logic [2:0]  state_q, state_d;
  addr_t       cur_addr_q, cur_addr_d;
  logic [15:0] rem_q, rem_d;
  addr_t       wr_addr_q, wr_addr_d;
  data_t       wr_din_q, wr_din_d;
  logic        wr_we_q, wr_we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        hs, stall_en, stall_clr, expired;

  assign s_ready   = (state_q != DONE0);
  assign hs        = s_valid && s_ready;
  assign stall_en  = !s_valid && (state_q inside {H1, H2, H3, DATA});
  assign stall_clr = hs || (state_q == H0) || (state_q == DONE0);

  stall_timer #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_stall_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (stall_en),
    .clr    (stall_clr),
    .expired(expired)
  );

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    wr_addr_d  = wr_addr_q;
    wr_din_d   = wr_din_q;
    wr_we_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    case (state_q)
      // busy lingers one cycle after the last byte so the final write still owns the port.
      H0: begin
        busy_d = 1'b0;
        if (hs) begin
          cur_addr_d = {s_data, cur_addr_q[7:0]};
          err_d      = 1'b0;
          busy_d     = 1'b1;
          state_d    = H1;
        end
      end
      H1: if (hs) begin
        cur_addr_d = {cur_addr_q[15:8], s_data};
        state_d    = H2;
      end
      H2: if (hs) begin
        rem_d   = {s_data, 8'h00};
        state_d = H2 + 3'd1;
      end
      H3: if (hs) begin
        rem_d = {rem_q[15:8], s_data};
        if ({rem_q[15:8], s_data} == 16'h0000) begin
          done_d  = 1'b1;
          state_d = DONE0;
        end else begin
          state_d = DATA;
        end
      end
      DATA: if (hs) begin
        wr_addr_d  = cur_addr_q;
        wr_din_d   = s_data;
        wr_we_d    = is_ram(cur_addr_q);
        err_d      = err_q || !is_ram(cur_addr_q);
        cur_addr_d = cur_addr_q + 1'b1;
        rem_d      = rem_q - 1'b1;
        if (rem_q == 16'h0001) begin
          done_d  = 1'b1;
          state_d = H0;
        end
      end
      DONE0: begin
        busy_d  = 1'b0;
        state_d = H0;
      end
      default: state_d = H0;
    endcase
    if (expired) begin
      state_d = H0;
      err_d   = 1'b1;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= H0;
      cur_addr_q <= '0;
      rem_q      <= '0;
      wr_addr_q  <= '0;
      wr_din_q   <= '0;
      wr_we_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      wr_addr_q  <= wr_addr_d;
      wr_din_q   <= wr_din_d;
      wr_we_q    <= wr_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign mem_addr = busy_q ? wr_addr_q : cpu_addr;
  assign mem_din  = busy_q ? wr_din_q  : cpu_din;
  assign mem_we   = busy_q ? wr_we_q   : cpu_we;

endmodule
